// File: rtl/dma_lite_pkg.sv
// dma_lite_pkg: shared register map, arbiter state encoding and timeout default
package dma_lite_pkg;
   localparam logic [9:0] MM2S_DMACR  = 10'h000;
   localparam logic [9:0] MM2S_DMASR  = 10'h004;
   localparam logic [9:0] MM2S_SA     = 10'h018;
   localparam logic [9:0] MM2S_SA_MSB = 10'h01C;
   localparam logic [9:0] MM2S_LENGTH = 10'h028;
   localparam logic [9:0] S2MM_DMACR  = 10'h030;
   localparam logic [9:0] S2MM_DMASR  = 10'h034;
   localparam logic [9:0] S2MM_DA     = 10'h048;
   localparam logic [9:0] S2MM_DA_MSB = 10'h04C;
   localparam logic [9:0] S2MM_LENGTH = 10'h058;
   localparam int DEF_TIMEOUT = 256;
   typedef enum logic [2:0] {
      S_IDLE  = 3'b001,
      S_ISSUE = 3'b010,
      S_HOLD  = 3'b100
   } state_t;
endpackage

// File: rtl/dma_lite_arbiter_rr.sv
// rr_arbiter: combinational round-robin picker
//  i_req  requests, i_ptr highest-priority index
//  o_gnt  one-hot winner, o_idx winner index, o_any some request present
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic [N-1:0]         i_req,
   input  logic [$clog2(N)-1:0] i_ptr,
   output logic [N-1:0]         o_gnt,
   output logic [$clog2(N)-1:0] o_idx,
   output logic                 o_any
);
   localparam int IW = $clog2(N);
   function automatic logic [IW-1:0] wrap(input int v);
      return IW'(v % N);
   endfunction
   always_comb begin
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      for (int k = 0; k < N; k++)
         if (!o_any && i_req[wrap(int'(i_ptr) + k)]) begin
            o_any = 1'b1;
            o_gnt[wrap(int'(i_ptr) + k)] = 1'b1;
            o_idx = wrap(int'(i_ptr) + k);
         end
   end
endmodule

// File: rtl/dma_lite_arbiter.sv
// dma_lite_arbiter: round-robin sharing of the DMA AXI-Lite register-write port with sequence lock
//  req_valid/addr/wdata/last  per-requester write requests (packed)
//  req_done/req_err           1-cycle completion / timeout pulses to the owner
//  grant, busy                current owner (one-hot) and non-idle flag
//  lite_valid/awaddr/wdata    write to the lite master; lite_end its response pulse
module dma_lite_arbiter
   import dma_lite_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 10,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*32-1:0]     req_wdata,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic [NUM_REQ-1:0]        req_done,
   output logic [NUM_REQ-1:0]        req_err,
   output logic [NUM_REQ-1:0]        grant,
   output logic                      busy,
   output logic [31:0]               lite_wdata,
   output logic [ADDR_W-1:0]         lite_awaddr,
   output logic                      lite_valid,
   input  logic                      lite_end
);
   localparam int IW = $clog2(NUM_REQ);
   state_t              r_state;
   logic [IW-1:0]       r_ptr, r_owner;
   logic [NUM_REQ-1:0]  r_grant, r_done, r_err;
   logic                r_last, r_valid;
   logic [ADDR_W-1:0]   r_addr;
   logic [31:0]         r_wdata, r_timer;
   logic [NUM_REQ-1:0]  w_req, w_gnt;
   logic [IW-1:0]       w_idx, w_sel, w_next;
   logic                w_any, w_go, w_tmo;
   // requester inputs are stale while a done/err pulse is out, so mask them
   assign w_req  = (|r_done || |r_err) ? '0 : req_valid;
   assign w_sel  = r_state == S_HOLD ? r_owner : w_idx;
   assign w_go   = r_state == S_IDLE ? w_any : r_state == S_HOLD && w_req[r_owner];
   assign w_tmo  = TIMEOUT != 0 && r_timer == 32'(TIMEOUT - 1);
   assign w_next = r_owner == IW'(NUM_REQ - 1) ? '0 : r_owner + 1'b1;
   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .i_req (w_req),
      .i_ptr (r_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_idx),
      .o_any (w_any)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_owner <= '0;
         r_grant <= '0;
         r_done  <= '0;
         r_err   <= '0;
         r_last  <= 1'b0;
         r_valid <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_timer <= '0;
      end else begin
         r_done <= '0;
         r_err  <= '0;
         case (r_state)
            S_ISSUE:
               if (lite_end) begin
                  r_valid <= 1'b0;
                  r_done  <= r_grant;
                  r_timer <= '0;
                  if (r_last) begin
                     r_grant <= '0;
                     r_ptr   <= w_next;
                     r_state <= S_IDLE;
                  end else
                     r_state <= S_HOLD;
               end else if (w_tmo) begin
                  // a hung slave aborts the whole sequence, lock released regardless of last
                  r_valid <= 1'b0;
                  r_err   <= r_grant;
                  r_grant <= '0;
                  r_ptr   <= w_next;
                  r_timer <= '0;
                  r_state <= S_IDLE;
               end else
                  r_timer <= r_timer + 32'd1;
            default:
               if (w_go) begin
                  r_state <= S_ISSUE;
                  r_valid <= 1'b1;
                  r_grant <= r_state == S_HOLD ? r_grant : w_gnt;
                  r_owner <= w_sel;
                  r_addr  <= req_addr[w_sel*ADDR_W +: ADDR_W];
                  r_wdata <= req_wdata[w_sel*32 +: 32];
                  r_last  <= req_last[w_sel];
                  r_timer <= '0;
               end
         endcase
      end
   end
   assign req_done    = r_done;
   assign req_err     = r_err;
   assign grant       = r_grant;
   assign busy        = r_state != S_IDLE;
   assign lite_wdata  = r_wdata;
   assign lite_awaddr = r_addr;
   assign lite_valid  = r_valid;
endmodule

// File: tb/tb_dma_lite_arbiter.sv
// tb_dma_lite_arbiter: scoreboard bench for the lite-port arbiter
module tb_dma_lite_arbiter;
   import dma_lite_pkg::*;
   localparam int AW = 10, TO = 16;
   typedef struct {logic [AW-1:0] a; logic [31:0] d; logic l; int gap;} wr_t;
   typedef struct {logic [AW-1:0] a; logic [31:0] d; logic [1:0] g; int len;} exp_t;
   typedef struct {logic [1:0] done; logic [1:0] err;} rsp_t;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   logic rv[2];
   logic [AW-1:0] ra[2];
   logic [31:0] rd[2];
   logic rl[2];
   logic [1:0] req_valid, req_last, req_done, req_err, grant;
   logic [2*AW-1:0] req_addr;
   logic [63:0] req_wdata;
   logic busy, lite_valid, lite_end;
   logic [31:0] lite_wdata;
   logic [AW-1:0] lite_awaddr;
   assign req_valid = {rv[1], rv[0]};
   assign req_addr  = {ra[1], ra[0]};
   assign req_wdata = {rd[1], rd[0]};
   assign req_last  = {rl[1], rl[0]};
   dma_lite_arbiter #(.NUM_REQ(2), .ADDR_W(AW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_last(req_last), .req_done(req_done), .req_err(req_err), .grant(grant), .busy(busy),
      .lite_wdata(lite_wdata), .lite_awaddr(lite_awaddr), .lite_valid(lite_valid), .lite_end(lite_end)
   );
   wr_t q0[$], q1[$];
   exp_t exp_q[$];
   rsp_t rsp_q[$];
   int n_chk = 0, n_pass = 0;
   logic dbusy[2];
   logic abort = 1'b0, stray = 1'b0;
   int lat[2];
   logic [AW-1:0] t1a[5] = '{MM2S_DMACR, MM2S_SA, MM2S_SA_MSB, MM2S_LENGTH, MM2S_DMASR};
   logic [AW-1:0] t2a[4] = '{MM2S_DMACR, MM2S_SA, MM2S_SA_MSB, MM2S_LENGTH};
   int t2g[4] = '{0, 2, 3, 1};
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   task automatic push_req(input int r, input logic [AW-1:0] a, input logic [31:0] d, input logic l, input int gap);
      wr_t w;
      w = '{a, d, l, gap};
      if (r == 0) q0.push_back(w); else q1.push_back(w);
   endtask
   // rsp: 0 none, 1 done, 2 err
   task automatic push_exp(input int r, input logic [AW-1:0] a, input logic [31:0] d, input int len, input int rsp);
      exp_q.push_back('{a, d, 2'(1 << r), len});
      if (rsp == 1) rsp_q.push_back('{2'(1 << r), 2'b00});
      if (rsp == 2) rsp_q.push_back('{2'b00, 2'(1 << r)});
   endtask
   function automatic int qsz(input int r);
      return r == 0 ? q0.size() : q1.size();
   endfunction
   task automatic drv(input int r);
      wr_t w;
      int cnt;
      forever begin
         if (qsz(r) == 0 || abort) begin
            rv[r] = 1'b0;
            dbusy[r] = 1'b0;
            @(posedge clk); #1;
         end else begin
            dbusy[r] = 1'b1;
            if (r == 0) w = q0.pop_front(); else w = q1.pop_front();
            if (w.gap > 0) begin
               rv[r] = 1'b0;
               repeat (w.gap) begin @(posedge clk); #1; end
            end
            rv[r] = 1'b1; ra[r] = w.a; rd[r] = w.d; rl[r] = w.l;
            cnt = 0;
            while (!(req_done[r] || req_err[r]) && !abort && cnt < 500) begin
               @(posedge clk); #1;
               cnt++;
            end
            if (!abort) begin
               chk($sformatf("resp_wait%0d", r), 64'(cnt < 500), 64'd1);
               @(posedge clk); #1;
            end
         end
      end
   endtask
   initial drv(0);
   initial drv(1);
   int hi_s = 0;
   initial begin
      lite_end = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (lite_valid) hi_s++; else hi_s = 0;
         lite_end = lite_valid && lat[grant[1]] != 0 && hi_s == lat[grant[1]];
         if (stray) begin
            lite_end = 1'b1;
            stray = 1'b0;
         end
      end
   end
   logic prev_v = 1'b0;
   int hi = 0, cur_len = 0;
   always @(negedge clk) begin
      exp_t e;
      rsp_t s;
      if (rst) begin
         prev_v = 1'b0;
         cur_len = 0;
      end else begin
         if (lite_valid && !prev_v) begin
            hi = 0;
            if (exp_q.size() == 0) begin
               chk("unexp_wr", 64'(lite_awaddr), 64'h3ff_ffff);
               cur_len = 0;
            end else begin
               e = exp_q.pop_front();
               chk("wr_addr", 64'(lite_awaddr), 64'(e.a));
               chk("wr_data", 64'(lite_wdata), 64'(e.d));
               chk("wr_grant", 64'(grant), 64'(e.g));
               cur_len = e.len;
            end
         end
         if (lite_valid) hi++;
         if (!lite_valid && prev_v && cur_len != 0) chk("wr_len", 64'(hi), 64'(cur_len));
         if (|req_done || |req_err) begin
            if (rsp_q.size() == 0) chk("unexp_rsp", 64'({req_done, req_err}), 64'd0);
            else begin
               s = rsp_q.pop_front();
               chk("rsp_done", 64'(req_done), 64'(s.done));
               chk("rsp_err", 64'(req_err), 64'(s.err));
            end
         end
         prev_v = lite_valid;
      end
   end
   task automatic drain(input string tag);
      int cnt = 0;
      @(negedge clk);
      while (!(q0.size() == 0 && q1.size() == 0 && !dbusy[0] && !dbusy[1] &&
               exp_q.size() == 0 && rsp_q.size() == 0 && !busy) && cnt < 3000) begin
         @(negedge clk);
         cnt++;
      end
      chk(tag, 64'(cnt < 3000), 64'd1);
   endtask
   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask
   task automatic chk_quiet(input string tag);
      chk({tag, "_valid"}, 64'(lite_valid), 64'd0);
      chk({tag, "_grant"}, 64'(grant), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_resp"}, 64'({req_done, req_err}), 64'd0);
   endtask
   initial begin
      lat[0] = 3;
      lat[1] = 2;
      do_reset();
      chk_quiet("rst");
      chk("rst_addr", 64'(lite_awaddr), 64'd0);
      chk("rst_data", 64'(lite_wdata), 64'd0);
      // 1: single requester, five-write sequence
      for (int i = 0; i < 5; i++) begin
         push_req(0, t1a[i], 32'hA5A5_0000 + i, i == 4, 0);
         push_exp(0, t1a[i], 32'hA5A5_0000 + i, 3, 1);
      end
      drain("t1_drain");
      chk("t1_grant", 64'(grant), 64'd0);
      // 2: lock held by req0 across HOLD gaps
      do_reset();
      for (int i = 0; i < 4; i++) begin
         push_req(0, t2a[i], 32'hB000_0000 + i, i == 3, t2g[i]);
         push_exp(0, t2a[i], 32'hB000_0000 + i, 3, 1);
      end
      push_req(1, S2MM_DMACR, 32'hB100_0000, 1'b1, 0);
      push_exp(1, S2MM_DMACR, 32'hB100_0000, 2, 1);
      drain("t2_drain");
      // 3: alternating single writes
      for (int i = 0; i < 4; i++) begin
         push_req(0, MM2S_DMASR, 32'hC000_0000 + i, 1'b1, 0);
         push_req(1, S2MM_DMASR, 32'hC100_0000 + i, 1'b1, 0);
         push_exp(0, MM2S_DMASR, 32'hC000_0000 + i, 3, 1);
         push_exp(1, S2MM_DMASR, 32'hC100_0000 + i, 2, 1);
      end
      drain("t3_drain");
      // 4: timeout on req0, pending req1 served next
      lat[0] = 0;
      push_req(0, MM2S_LENGTH, 32'hD000_0000, 1'b0, 0);
      push_req(1, S2MM_LENGTH, 32'hD100_0000, 1'b1, 0);
      push_exp(0, MM2S_LENGTH, 32'hD000_0000, TO, 2);
      push_exp(1, S2MM_LENGTH, 32'hD100_0000, 2, 1);
      drain("t4_drain");
      chk("t4_grant", 64'(grant), 64'd0);
      // 5: lite_end on the timeout terminal cycle, then a stray lite_end while idle
      lat[0] = TO;
      push_req(0, MM2S_DMACR, 32'hE000_0000, 1'b1, 0);
      push_exp(0, MM2S_DMACR, 32'hE000_0000, TO, 1);
      drain("t5_drain");
      stray = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk_quiet("stray");
      end
      // 6: reset during ISSUE
      lat[0] = 0;
      push_req(0, MM2S_SA, 32'hF000_0000, 1'b1, 0);
      push_exp(0, MM2S_SA, 32'hF000_0000, 0, 0);
      begin
         int cnt = 0;
         while (!lite_valid && cnt < 50) begin @(negedge clk); cnt++; end
      end
      chk("t6_issue", 64'(lite_valid), 64'd1);
      repeat (2) @(negedge clk);
      abort = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk_quiet("t6_rst");
      abort = 1'b0;
      lat[0] = 3;
      push_req(0, MM2S_SA, 32'hF000_0001, 1'b1, 0);
      push_req(1, S2MM_DA, 32'hF100_0001, 1'b1, 0);
      push_exp(0, MM2S_SA, 32'hF000_0001, 3, 1);
      push_exp(1, S2MM_DA, 32'hF100_0001, 2, 1);
      drain("t6_drain");
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
